// File: rtl/conv_bram_pkg.sv
// conv_bram_pkg
// Purpose: shared parameter defaults and the bank-index width derivation for
//          the convolution row-BRAM router.
// Contents:
//   DEF_*    default values for the conv_bram_router parameters
//   calc_bw  bank-index width for a given bank count (never below 1 bit)
package conv_bram_pkg;

  localparam int unsigned DEF_PIXELS_IN_ROW = 32;
  localparam int unsigned DEF_NUM_ROWS      = 3;
  localparam int unsigned DEF_NUM_BANKS     = 4;
  localparam int unsigned DEF_ADR_W         = 16;
  localparam int unsigned DEF_SLAB_W        = 16;
  localparam int unsigned DEF_RD_LAT        = 1;

  function automatic int unsigned calc_bw(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/conv_bram_lat_pipe.sv
// conv_bram_lat_pipe
// Purpose: enable-gated, synchronously resettable delay line of RD_LAT stages.
//          Carries read-request tags ({bank index, valid}) and slab write-back
//          requests ({adr, en}) alongside the BRAM read latency.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset; loads RST_VAL into every stage
//   i_en     advance; 0 holds every stage
//   i_d      value entering the first stage
//   o_q      value leaving the last stage
module conv_bram_lat_pipe #(
  parameter int unsigned W       = 1,
  parameter int unsigned RD_LAT  = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [RD_LAT];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[RD_LAT-1];

endmodule

// File: rtl/conv_bram_router.sv
// conv_bram_router
// Purpose: routes NUM_ROWS kernel-row read requests onto a rotating set of
//          NUM_BANKS row BRAM banks, returns the read data per row after the
//          BRAM latency, and writes the slab word of each issued read back to
//          its bank RD_LAT cycles later.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   en                  global advance; 0 stalls everything
//   row_adr/row_valid   per-row read requests
//   row_advance         rotate the row-to-bank mapping by advance_by
//   bank_adr/bank_en    per-bank read port
//   bank_rd_data        per-bank pixel read data (RD_LAT after bank_en)
//   slab_rd_data        per-bank slab read data (same timing)
//   row_pixels/row_slab/row_data_valid   per-row returned data
//   slab_wr_adr/slab_wr_data/slab_wr_en  per-bank slab write-back
//   fill_bank           first bank not mapped to a row (next to refill)
//   base                current rotation base
// NUM_BANKS must exceed NUM_ROWS, RD_LAT must be at least 1, and BW must be
// left at its derived default.
module conv_bram_router
  import conv_bram_pkg::*;
#(
  parameter int unsigned PIXELS_IN_ROW = DEF_PIXELS_IN_ROW,
  parameter int unsigned NUM_ROWS      = DEF_NUM_ROWS,
  parameter int unsigned NUM_BANKS     = DEF_NUM_BANKS,
  parameter int unsigned ADR_W         = DEF_ADR_W,
  parameter int unsigned SLAB_W        = DEF_SLAB_W,
  parameter int unsigned RD_LAT        = DEF_RD_LAT,
  parameter int unsigned BW            = calc_bw(NUM_BANKS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic [NUM_ROWS*ADR_W-1:0]            row_adr,
  input  logic [NUM_ROWS-1:0]                  row_valid,
  input  logic                                 row_advance,
  input  logic [BW-1:0]                        advance_by,
  output logic [NUM_BANKS*ADR_W-1:0]           bank_adr,
  output logic [NUM_BANKS-1:0]                 bank_en,
  input  logic [NUM_BANKS*PIXELS_IN_ROW*8-1:0] bank_rd_data,
  input  logic [NUM_BANKS*SLAB_W-1:0]          slab_rd_data,
  output logic [NUM_ROWS*PIXELS_IN_ROW*8-1:0]  row_pixels,
  output logic [NUM_ROWS*SLAB_W-1:0]           row_slab,
  output logic [NUM_ROWS-1:0]                  row_data_valid,
  output logic [NUM_BANKS*ADR_W-1:0]           slab_wr_adr,
  output logic [NUM_BANKS*SLAB_W-1:0]          slab_wr_data,
  output logic [NUM_BANKS-1:0]                 slab_wr_en,
  output logic [BW-1:0]                        fill_bank,
  output logic [BW-1:0]                        base
);

  localparam int unsigned PW = PIXELS_IN_ROW * 8;
  localparam logic [BW+1:0] NB_W = (BW+2)'(NUM_BANKS);

  // (a + b) mod NUM_BANKS. a < NUM_BANKS and b < 2**BW < 2*NUM_BANKS, so the
  // sum stays below 3*NUM_BANKS and two conditional subtractions suffice.
  function automatic logic [BW-1:0] wrap_add(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW+1:0] sum;
    sum = {2'b00, a} + {2'b00, b};
    for (int k = 0; k < 2; k++) begin
      if (sum >= NB_W) sum = sum - NB_W;
    end
    return sum[BW-1:0];
  endfunction

  logic [BW-1:0] r_base;
  logic          w_live;
  logic [BW-1:0] w_row_bank  [NUM_ROWS];
  logic [BW:0]   w_row_pipe  [NUM_ROWS];
  logic [ADR_W:0] w_bank_pipe [NUM_BANKS];

  // Requests are issued and results presented only in enabled, non-reset cycles.
  assign w_live    = en & ~reset;
  assign base      = r_base;
  assign fill_bank = wrap_add(r_base, BW'(NUM_ROWS));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0;
    end else if (en && row_advance) begin
      r_base <= wrap_add(r_base, advance_by);
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    assign w_row_bank[r] = wrap_add(r_base, BW'(r));

    // Tag each request with the bank it went to, so returns ignore later rotations.
    conv_bram_lat_pipe #(
      .W      (BW + 1),
      .RD_LAT (RD_LAT),
      .RST_VAL('0)
    ) u_row_pipe (
      .i_clk  (clk),
      .i_reset(reset),
      .i_en   (en),
      .i_d    ({w_row_bank[r], row_valid[r]}),
      .o_q    (w_row_pipe[r])
    );
  end

  // Row-to-bank mapping is a rotation, so at most one row hits each bank.
  always_comb begin
    bank_adr = '0;
    bank_en  = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      for (int r = 0; r < int'(NUM_ROWS); r++) begin
        if (w_live && row_valid[r] && (w_row_bank[r] == BW'(b))) begin
          bank_adr[b*ADR_W +: ADR_W] = row_adr[r*ADR_W +: ADR_W];
          bank_en[b]                 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    row_pixels     = '0;
    row_slab       = '0;
    row_data_valid = '0;
    for (int r = 0; r < int'(NUM_ROWS); r++) begin
      if (w_live && w_row_pipe[r][0]) begin
        row_data_valid[r] = 1'b1;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
          if (w_row_pipe[r][BW:1] == BW'(b)) begin
            row_pixels[r*PW +: PW]         = bank_rd_data[b*PW +: PW];
            row_slab[r*SLAB_W +: SLAB_W]   = slab_rd_data[b*SLAB_W +: SLAB_W];
          end
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    // Address lanes reset to all ones so an idle write port points nowhere useful.
    conv_bram_lat_pipe #(
      .W      (ADR_W + 1),
      .RD_LAT (RD_LAT),
      .RST_VAL({{ADR_W{1'b1}}, 1'b0})
    ) u_wb_pipe (
      .i_clk  (clk),
      .i_reset(reset),
      .i_en   (en),
      .i_d    ({bank_adr[b*ADR_W +: ADR_W], bank_en[b]}),
      .o_q    (w_bank_pipe[b])
    );

    assign slab_wr_adr[b*ADR_W +: ADR_W]   = w_bank_pipe[b][ADR_W:1];
    assign slab_wr_en[b]                   = w_bank_pipe[b][0] & w_live;
    assign slab_wr_data[b*SLAB_W +: SLAB_W] = bank_rd_data[b*PW +: SLAB_W];
  end

endmodule

// File: tb/tb_conv_bram_router.sv
// tb_conv_bram_router
// Purpose: directed self-checking bench for conv_bram_router at default
//          parameters. Each bank returns a constant, bank-identifying pattern
//          so the returned row data shows which bank served it.
module tb_conv_bram_router;

  localparam int NR = 3;
  localparam int NB = 4;
  localparam int AW = 16;
  localparam int SW = 16;
  localparam int PW = 256;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [NR*AW-1:0]  row_adr;
  logic [NR-1:0]     row_valid;
  logic              row_advance;
  logic [BW-1:0]     advance_by;
  logic [NB*AW-1:0]  bank_adr;
  logic [NB-1:0]     bank_en;
  logic [NB*PW-1:0]  bank_rd_data;
  logic [NB*SW-1:0]  slab_rd_data;
  logic [NR*PW-1:0]  row_pixels;
  logic [NR*SW-1:0]  row_slab;
  logic [NR-1:0]     row_data_valid;
  logic [NB*AW-1:0]  slab_wr_adr;
  logic [NB*SW-1:0]  slab_wr_data;
  logic [NB-1:0]     slab_wr_en;
  logic [BW-1:0]     fill_bank;
  logic [BW-1:0]     base;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_bram_router dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .row_adr       (row_adr),
    .row_valid     (row_valid),
    .row_advance   (row_advance),
    .advance_by    (advance_by),
    .bank_adr      (bank_adr),
    .bank_en       (bank_en),
    .bank_rd_data  (bank_rd_data),
    .slab_rd_data  (slab_rd_data),
    .row_pixels    (row_pixels),
    .row_slab      (row_slab),
    .row_data_valid(row_data_valid),
    .slab_wr_adr   (slab_wr_adr),
    .slab_wr_data  (slab_wr_data),
    .slab_wr_en    (slab_wr_en),
    .fill_bank     (fill_bank),
    .base          (base)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] word(input int b);
    logic [7:0] p;
    p = 8'hA0 + 8'(b);
    return {32{p}};
  endfunction

  function automatic logic [255:0] pix(input int r);
    return row_pixels[r*PW +: PW];
  endfunction

  function automatic logic [15:0] slab(input int r);
    return row_slab[r*SW +: SW];
  endfunction

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      bank_rd_data[b*PW +: PW] = word(b);
      slab_rd_data[b*SW +: SW] = 16'h5000 + 16'(b);
    end
    reset       = 1'b1;
    en          = 1'b1;
    row_valid   = 3'b111;
    row_adr     = {16'd30, 16'd20, 16'd10};
    row_advance = 1'b1;
    advance_by  = 2'd1;

    // Reset held two cycles with live requests and an advance pending.
    step();
    step();
    #1;
    check("rst_base", base, 0);
    check("rst_bank_en", bank_en, 4'b0000);
    check("rst_wr_adr", slab_wr_adr, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_rdv", row_data_valid, 3'b000);
    check("rst_wr_en", slab_wr_en, 4'b0000);
    check("rst_fill", fill_bank, 2'd3);

    // Basic mapping at base 0.
    reset       = 1'b0;
    row_advance = 1'b0;
    #1;
    check("map_adr", bank_adr, {16'd0, 16'd30, 16'd20, 16'd10});
    check("map_en", bank_en, 4'b0111);

    step();
    row_valid = 3'b101;
    row_adr   = {16'h33, 16'h22, 16'h11};
    #1;
    check("ret_rdv", row_data_valid, 3'b111);
    for (int r = 0; r < NR; r++) begin
      check($sformatf("ret_pix%0d", r), pix(r), word(r));
      check($sformatf("ret_slab%0d", r), slab(r), 16'h5000 + 16'(r));
    end
    check("wb_en", slab_wr_en, 4'b0111);
    check("wb_adr", slab_wr_adr, {16'd0, 16'd30, 16'd20, 16'd10});
    check("wb_data1", slab_wr_data[SW +: SW], 16'hA1A1);
    // Masked row 1.
    check("mask_en", bank_en, 4'b0101);
    check("mask_adr", bank_adr, {16'h0, 16'h33, 16'h0, 16'h11});

    step();
    row_valid   = 3'b111;
    row_adr     = {16'd3, 16'd2, 16'd1};
    row_advance = 1'b1;
    advance_by  = 2'd1;
    #1;
    check("mask_rdv", row_data_valid, 3'b101);
    check("mask_pix1", pix(1), 0);
    check("mask_slab1", slab(1), 0);
    check("mask_pix2", pix(2), word(2));
    // Advance cycle still issues on the old mapping.
    check("adv_old_en", bank_en, 4'b0111);
    check("adv_old_base", base, 0);

    step();
    row_advance = 1'b0;
    row_adr     = {16'd6, 16'd5, 16'd4};
    #1;
    check("adv_base", base, 2'd1);
    check("adv_fill", fill_bank, 2'd0);
    check("adv_rdv", row_data_valid, 3'b111);
    check("adv_pix0", pix(0), word(0));
    check("adv_pix2", pix(2), word(2));
    check("adv_new_en", bank_en, 4'b1110);
    check("adv_new_adr", bank_adr, {16'd6, 16'd5, 16'd4, 16'd0});

    step();
    row_valid   = 3'b000;
    row_advance = 1'b1;
    advance_by  = 2'd2;
    #1;
    check("new_pix0", pix(0), word(1));
    check("new_pix2", pix(2), word(3));
    check("new_wb_adr", slab_wr_adr, {16'd6, 16'd5, 16'd4, 16'd0});
    check("idle_en", bank_en, 4'b0000);

    // base 1 + 2 -> 3; then 3 + 2 wraps to 1.
    step();
    row_valid = 3'b111;
    row_adr   = {16'd9, 16'd8, 16'd7};
    #1;
    check("wrap_base3", base, 2'd3);
    check("wrap_fill2", fill_bank, 2'd2);
    check("wrap_en", bank_en, 4'b1011);
    check("wrap_adr", bank_adr, {16'd7, 16'd0, 16'd9, 16'd8});
    check("wrap_rdv0", row_data_valid, 3'b000);

    step();
    row_valid  = 3'b000;
    advance_by = 2'd0;
    #1;
    check("wrap_base1", base, 2'd1);
    check("wrap_fill0", fill_bank, 2'd0);
    check("wrap_pix0", pix(0), word(3));
    check("wrap_pix1", pix(1), word(0));
    check("wrap_pix2", pix(2), word(1));

    step();
    row_valid   = 3'b111;
    row_adr     = {16'hC, 16'hB, 16'hA};
    row_advance = 1'b0;
    #1;
    check("adv0_base", base, 2'd1);

    // Stall for three cycles; an advance request during the stall is ignored.
    for (int i = 0; i < 3; i++) begin
      step();
      en          = 1'b0;
      row_advance = 1'b1;
      advance_by  = 2'd1;
      #1;
      check($sformatf("stall%0d_rdv", i), row_data_valid, 3'b000);
      check($sformatf("stall%0d_wr_en", i), slab_wr_en, 4'b0000);
      check($sformatf("stall%0d_bank_en", i), bank_en, 4'b0000);
      check($sformatf("stall%0d_base", i), base, 2'd1);
    end
    step();
    en          = 1'b1;
    row_valid   = 3'b000;
    row_advance = 1'b0;
    #1;
    check("unstall_rdv", row_data_valid, 3'b111);
    check("unstall_wr_en", slab_wr_en, 4'b1110);
    check("unstall_wr_adr", slab_wr_adr, {16'hC, 16'hB, 16'hA, 16'h0});
    check("unstall_pix0", pix(0), word(1));
    check("unstall_base", base, 2'd1);

    step();
    #1;
    check("post_rdv", row_data_valid, 3'b000);

    // Reset with a request in flight (held by a stall) discards it.
    row_valid = 3'b111;
    step();
    reset = 1'b1;
    en    = 1'b0;
    step();
    reset = 1'b0;
    en    = 1'b1;
    row_valid = 3'b000;
    #1;
    check("flush_rdv", row_data_valid, 3'b000);
    check("flush_wr_en", slab_wr_en, 4'b0000);
    check("flush_wr_adr", slab_wr_adr, 64'hFFFF_FFFF_FFFF_FFFF);
    check("flush_base", base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_bram_router.md
CONV_BRAM_ROUTER -- requirements
Module: conv_bram_router

Interface
REQ-001 Parameters SHALL be:
  - PIXELS_IN_ROW, default 32, 8-bit pixels per bank read word.
  - NUM_ROWS, default 3, number of kernel rows presented in parallel.
  - NUM_BANKS, default 4, number of row BRAM banks; must be greater than NUM_ROWS.
  - ADR_W, default 16, address width.
  - SLAB_W, default 16, slab word width.
  - RD_LAT, default 1, BRAM read latency in cycles; must be 1 or more.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, single clock; rising edge.
  - reset, in, 1, synchronous, active-high.
  - en, in, 1, global advance/enable; 0 = stall.
  - row_adr, in, NUM_ROWS*ADR_W, read address per kernel row.
  - row_valid, in, NUM_ROWS, per-row request valid.
  - row_advance, in, 1, rotate the row-to-bank mapping.
  - advance_by, in, BW=clog2(NUM_BANKS), rotation step (conv stride).
  - bank_adr, out, NUM_BANKS*ADR_W, per-bank read address.
  - bank_en, out, NUM_BANKS, per-bank read enable.
  - bank_rd_data, in, NUM_BANKS*PIXELS_IN_ROW*8, bank read data, valid RD_LAT cycles after bank_en.
  - slab_rd_data, in, NUM_BANKS*SLAB_W, slab read data, same timing as bank_rd_data.
  - row_pixels, out, NUM_ROWS*PIXELS_IN_ROW*8, returned row data.
  - row_slab, out, NUM_ROWS*SLAB_W, returned slab data.
  - row_data_valid, out, NUM_ROWS, return valid.
  - slab_wr_adr, out, NUM_BANKS*ADR_W, slab write address.
  - slab_wr_data, out, NUM_BANKS*SLAB_W, slab write data.
  - slab_wr_en, out, NUM_BANKS, slab write enable.
  - fill_bank, out, BW, bank the loader shall refill next.
  - base, out, BW, current rotation base.

Function
REQ-003 Row r SHALL map to bank (base+r) mod NUM_BANKS; the mapping is held internally, with no per-row index inputs.
REQ-004 For each bank b with mapped row r, when en=1 and row_valid[r]=1: bank_adr[b]=row_adr[r] and bank_en[b]=1.
REQ-005 For each bank b with no mapped row, or with en=0, or with row_valid[r]=0: bank_adr[b]=0 and bank_en[b]=0.
REQ-006 When en=1 and row_advance=1, base SHALL update at the next edge to (base+advance_by) mod NUM_BANKS; advance_by=0 leaves base unchanged.
REQ-007 A new mapping SHALL take effect in the cycle after the advance edge; requests issued in the advance cycle use the old mapping.
REQ-008 fill_bank SHALL equal (base+NUM_ROWS) mod NUM_BANKS (combinational from base).
REQ-009 Each issued request SHALL capture its bank index and valid into an RD_LAT-deep pipeline that advances only when en=1.
REQ-010 After RD_LAT enabled cycles, row_pixels[r] and row_slab[r] SHALL select from the captured bank, not the current mapping.
REQ-011 row_data_valid[r] SHALL be the pipelined row_valid; when it is 0, row_pixels[r] and row_slab[r] SHALL be 0.
REQ-012 With en=0, all pipeline stages, base, and slab write registers SHALL hold; no bank_en or slab_wr_en is asserted.
REQ-013 Slab write-back: slab_wr_adr[b] and slab_wr_en[b] SHALL be bank_adr[b] and bank_en[b] delayed by RD_LAT enabled cycles.
REQ-014 slab_wr_data[b] SHALL be bank_rd_data[b][SLAB_W-1:0], combinational, aligned with slab_wr_en[b].

Reset
REQ-015 On reset=1 at a clock edge, the following SHALL hold, with reset overriding en and row_advance:
  - base=0.
  - All pipeline valids = 0.
  - row_data_valid = 0.
  - slab_wr_en = 0.
  - slab_wr_adr = all ones in every lane.
REQ-016 A reset asserted while requests are in flight SHALL discard them; no row_data_valid or slab_wr_en for those requests after reset releases.

Structure
REQ-017 Package conv_bram_pkg SHALL hold the parameter defaults and the BW derivation; bank-index arithmetic is done locally in the module.
REQ-018 Sub-module conv_bram_lat_pipe SHALL implement the enable-gated, resettable RD_LAT delay line for {bank index, valid} and for the write-back {adr, en}, instantiated per row and per bank.

Verification (defaults, RD_LAT=1)
REQ-019 Reset scenario: hold reset 2 cycles with en=1 and row_valid=111 -> base=0, bank_en=0000, slab_wr_adr lanes=FFFF, row_data_valid=000.
REQ-020 Basic mapping scenario: base=0, row_adr={30,20,10}, all valid -> bank_adr[0..2]=10,20,30 and bank_en=0111; next cycle row_data_valid=111 with row_pixels from banks 0,1,2.
REQ-021 Wrap scenario: base=3, advance_by=2 -> base=1, fill_bank=0.
REQ-022 Advance-in-flight scenario: with base=0, issue a read and row_advance=1 (advance_by=1) in the same cycle -> returned data comes from banks 0,1,2 while the next requests use banks 1,2,3.
REQ-023 Stall scenario: issue a read, then en=0 for 3 cycles -> row_data_valid and slab_wr_en are held at 0 (not asserted) during the stall, then assert one enabled cycle after en returns to 1.
REQ-024 Masked row scenario: row_valid=101 at base=0 -> bank_en=0101, bank_adr[1]=0; next cycle row_data_valid=101 and row_pixels[1]=0.
